imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
Instruction fetch controller that sequences the 64-word combinational instruction memory. It owns the fetch PC, drives the memory word address and captures each returned word with its PC into a small prefetch queue. Decode drains the queue over a valid/ready handshake. Branch and jump redirects flush the queue and restart fetch at a new PC.

Parameters:
ADDR_W, 6, instruction memory word-address width (memory depth 2^ADDR_W words)
DEPTH, 4, prefetch queue entries; power of two, at least 2
RESET_PC, 32'h0000_0000, byte PC loaded at reset; bits [1:0] must be 0

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
fetch_en  input  1  1 = fetching permitted; 0 = hold PC, no pushes
imem_addr  output  ADDR_W  word address to instruction memory = fetch_pc[ADDR_W+1:2]
imem_data  input  32  combinational read data for imem_addr
redirect_valid  input  1  one-cycle pulse: flush and restart fetch
redirect_pc  input  32  target byte PC; bits [1:0] ignored
out_valid  output  1  queue head holds a valid instruction
out_ready  input  1  decode accepts the head this cycle
out_instr  output  32  head instruction; 0 when out_valid=0
out_pc  output  32  byte PC of head instruction; 0 when out_valid=0
level  output  $clog2(DEPTH)+1  current queue occupancy

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_PC, wr_ptr=rd_ptr=0, level=0, out_valid=0, out_instr=0, out_pc=0. Queue storage is not reset.
- imem_addr is purely combinational from fetch_pc. imem_data is sampled in the same cycle; there is no memory wait state.
- pop = out_valid & out_ready.
- push = fetch_en & ~redirect_valid & (level<DEPTH | pop).
  - A push writes {fetch_pc, imem_data} at wr_ptr.
  - On a push, fetch_pc <= fetch_pc+4 (full 32-bit add, wraps at 2^32).
  - imem_addr wraps modulo 2^ADDR_W, so PC 0xFC is followed by word 0 at PC 0x100.
- Full queue with a simultaneous pop: push and pop both occur, level is unchanged.
- Full queue without a pop: no push, fetch_pc is held.
- Empty queue with a simultaneous push: no pop is possible (out_valid=0); level becomes 1 next cycle.
- Redirect has the highest priority. In the redirect cycle:
  - level<=0, pointers<=0, fetch_pc<={redirect_pc[31:2],2'b00}.
  - No push. The current head is still presented; a pop that cycle is ignored (flushed).
  - out_valid=0 in the next cycle; the first target instruction appears one cycle after that.
- Latency: PC presented at edge N is visible at out_valid/out_pc after edge N+1 (1 cycle). After reset release, out_pc=RESET_PC and out_valid=1 following the first rising edge with fetch_en=1.
- State machine, registered state:
  - RUN: normal operation.
  - FLUSH: entered on redirect_valid, lasts exactly one cycle. out_valid is forced 0 and a push is permitted. Returns to RUN.
  - Back-to-back redirects: each one reloads the PC; the last one wins.
- fetch_en=0 holds fetch_pc and suppresses pushes; pops continue. Deasserting fetch_en mid-stream loses no instruction.
- level = wr_ptr - rd_ptr, using pointers one bit wider than log2(DEPTH).
- out_instr/out_pc are combinational reads of the head entry, gated to 0 when level==0.
- Misuse (RESET_PC unaligned, DEPTH not a power of two): undefined. Flag it with a simulation-only check at time 0.

Test Plan:
- Reset, memory preloaded word k = 0x1000_0000+k, fetch_en=1, out_ready=1 -> out_pc 0x00,0x04,0x08… with out_instr 0x1000_0000,0x1000_0001… one per cycle; out_valid=1 from the first edge.
- out_ready=0 for 10 cycles, DEPTH=4 -> level saturates at 4, imem_addr stalls at 4. Release -> pcs 0x00–0x1C are delivered in order, none dropped or duplicated.
- Queue full, then redirect_valid with redirect_pc=0x0000_0023 -> next cycle level=0 and out_valid=0; then out_pc=0x20 with word 8. No pre-redirect entry is ever popped afterward.
- Fetch crosses 0xFC -> imem_addr goes 63 then 0; out_pc=0x100 carries word 0.
- Redirects on two consecutive cycles to 0x40 then 0x80 -> first delivered out_pc=0x80.
- rst_n asserted while level=3 -> out_valid=0 and level=0 immediately (asynchronously). After release, fetch resumes at RESET_PC.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : imem_fetch_ctrl
//  Purpose  : Instruction fetch controller for a combinational instruction
//             memory. Owns the fetch PC, drives the memory word address,
//             captures {pc, instruction} pairs into a small prefetch queue
//             and hands them to decode over a valid/ready handshake.
//             Redirects flush the queue and restart fetch at a new PC.
//  Ports    : clk, rst_n          - clock, async active-low reset
//             fetch_en            - fetch permitted (0 holds PC, no pushes)
//             imem_addr/imem_data - word address out, read data in
//             redirect_valid/pc   - flush and restart at redirect_pc
//             out_valid/ready     - decode handshake
//             out_instr/out_pc    - head entry (0 when not valid)
//             level               - queue occupancy
//  Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_ctrl #(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fetch_en,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [31:0]              imem_data,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned c_idx_w = $clog2(DEPTH);
  localparam int unsigned c_ptr_w = c_idx_w + 1;
  localparam logic [c_ptr_w-1:0] c_full_level = c_ptr_w'(DEPTH);

  localparam logic [0:0] c_st_run   = 1'b0;
  localparam logic [0:0] c_st_flush = 1'b1;

  // Misconfiguration is undefined behaviour; stop elaboration loudly.
  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("imem_fetch_ctrl: DEPTH must be a power of two >= 2");
    end
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
      $error("imem_fetch_ctrl: RESET_PC must be word aligned");
    end
  endgenerate

  logic [31:0]        r_fetch_pc;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [0:0]         r_state;

  logic [31:0]        r_q_pc    [DEPTH];
  logic [31:0]        r_q_instr [DEPTH];

  logic [c_ptr_w-1:0] w_level;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_unused;

  // Redirect targets are forced word aligned, so the low bits never matter.
  assign w_unused = ^redirect_pc[1:0];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_level   = r_wr_ptr - r_rd_ptr;
  assign level     = w_level;
  assign w_full    = (w_level == c_full_level);
  assign imem_addr = r_fetch_pc[ADDR_W+1:2];

  // The flush cycle hides the queue even though a new push is landing.
  assign out_valid = (w_level != '0) && (r_state == c_st_run);
  assign w_pop     = out_valid & out_ready;

  // A pop frees the slot in the same cycle, so a full queue can still push.
  assign w_push    = fetch_en & ~redirect_valid & (~w_full | w_pop);

  always_comb begin
    out_instr = '0;
    out_pc    = '0;
    if (out_valid) begin
      out_instr = r_q_instr[r_rd_ptr[c_idx_w-1:0]];
      out_pc    = r_q_pc[r_rd_ptr[c_idx_w-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_state    <= c_st_run;
    end else if (redirect_valid) begin
      // Redirect wins over everything; any pop this cycle is discarded.
      r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_state    <= c_st_flush;
    end else begin
      r_state <= c_st_run;
      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + 1'b1;
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Queue storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr[c_idx_w-1:0]]    <= r_fetch_pc;
      r_q_instr[r_wr_ptr[c_idx_w-1:0]] <= imem_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_imem_fetch_ctrl
//  Purpose  : Self-checking bench for imem_fetch_ctrl. Expected {pc, instr}
//             pairs are queued as the fetch stream is set up and compared as
//             decode accepts them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_ctrl;

  localparam int unsigned ADDR_W   = 6;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [$clog2(DEPTH):0] level;

  logic [31:0] mem [64];
  logic [63:0] sb [$];
  logic [63:0] r_exp;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  imem_fetch_ctrl #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .level          (level)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Expected word at byte PC pc: memory is loaded with 0x1000_0000 + index.
  function automatic void push_seq(input logic [31:0] start, input int n);
    logic [31:0] pc;
    for (int i = 0; i < n; i++) begin
      pc = start + 32'(4 * i);
      sb.push_back({pc, 32'h1000_0000 + {26'b0, pc[7:2]}});
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_addr(input logic [ADDR_W-1:0] a, input int budget);
    for (int i = 0; i < budget && imem_addr !== a; i++) tick();
    check_eq("wait_addr_timeout", {31'b0, imem_addr === a}, 32'd1);
  endtask

  task automatic wait_level(input int lv, input int budget);
    for (int i = 0; i < budget && level !== ($clog2(DEPTH)+1)'(lv); i++) tick();
    check_eq("wait_level_timeout", 32'(level), 32'(lv));
  endtask

  // Scoreboard consumer: a handshake not cancelled by a redirect pops one entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !redirect_valid) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 32'd1, 32'd0);
      end else begin
        r_exp = sb.pop_front();
        check_eq("out_pc", out_pc, r_exp[63:32]);
        check_eq("out_instr", out_instr, r_exp[31:0]);
      end
    end
  end

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = 32'h1000_0000 + 32'(k);
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_out_pc", out_pc, 32'd0);
    check_eq("rst_out_instr", out_instr, 32'd0);
    check_eq("rst_imem_addr", 32'(imem_addr), 32'(RESET_PC[7:2]));

    // Streaming fetch, one instruction per cycle, across the 0xFC wrap
    rst_n = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
    push_seq(RESET_PC, 80);
    tick();
    check_eq("first_valid", 32'(out_valid), 32'd1);
    check_eq("first_pc", out_pc, RESET_PC);
    check_eq("first_instr", out_instr, 32'h1000_0000);
    wait_addr(6'd63, 100);
    tick();
    check_eq("wrap_addr", 32'(imem_addr), 32'd0);
    tick();
    check_eq("wrap_pc", out_pc, 32'h0000_0100);
    check_eq("wrap_instr", out_instr, 32'h1000_0000);
    repeat (3) tick();

    // Back-pressure from reset: queue saturates and fetch stalls
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    out_ready = 1'b0;
    rst_n = 1'b1;
    push_seq(RESET_PC, 40);
    repeat (10) tick();
    check_eq("stall_level", 32'(level), 32'(DEPTH));
    check_eq("stall_addr", 32'(imem_addr), 32'd4);
    check_eq("stall_head_pc", out_pc, 32'd0);
    out_ready = 1'b1;
    repeat (12) tick();

    // fetch_en low drains the queue without losing the stream position
    fetch_en = 1'b0;
    repeat (6) tick();
    check_eq("fe_off_level", 32'(level), 32'd0);
    check_eq("fe_off_valid", 32'(out_valid), 32'd0);
    fetch_en = 1'b1;
    repeat (4) tick();

    // Redirect out of a full queue; the pop in the redirect cycle is dropped
    out_ready = 1'b0;
    wait_level(DEPTH, 10);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0023;
    out_ready      = 1'b1;
    sb.delete();
    push_seq(32'h0000_0020, 40);
    tick();
    redirect_valid = 1'b0;
    check_eq("redir_level", 32'(level), 32'd0);
    check_eq("redir_valid", 32'(out_valid), 32'd0);
    check_eq("redir_pc_gated", out_pc, 32'd0);
    tick();
    check_eq("redir_tgt_valid", 32'(out_valid), 32'd1);
    check_eq("redir_tgt_pc", out_pc, 32'h0000_0020);
    check_eq("redir_tgt_instr", out_instr, 32'h1000_0008);
    repeat (5) tick();

    // Back-to-back redirects: the later target wins
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    sb.delete();
    tick();
    redirect_pc = 32'h0000_0080;
    sb.delete();
    push_seq(32'h0000_0080, 40);
    tick();
    redirect_valid = 1'b0;
    check_eq("b2b_flush_valid", 32'(out_valid), 32'd0);
    tick();
    check_eq("b2b_pc", out_pc, 32'h0000_0080);
    check_eq("b2b_instr", out_instr, 32'h1000_0020);
    repeat (4) tick();

    // Asynchronous reset while three entries are queued
    out_ready = 1'b0;
    wait_level(3, 10);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 32'(out_valid), 32'd0);
    check_eq("arst_level", 32'(level), 32'd0);
    check_eq("arst_pc", out_pc, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    push_seq(RESET_PC, 40);
    tick();
    check_eq("arst_resume_valid", 32'(out_valid), 32'd1);
    check_eq("arst_resume_pc", out_pc, RESET_PC);
    repeat (6) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
